multicycle_ctrl: RTL

Multi-cycle control sequencer for the RV32I core's shared datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. In each state it drives the ALU operand-B select (`alu_src`: 0 = register rs2, 1 = immediate), the immediate-format select, and the register-file, memory and PC enables. This lets one ALU and one memory port be reused across cycles. It sits between the instruction register and the datapath, replacing per-opcode combinational control of the single-cycle build.

---
 rtl/multicycle_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the shared RV32I datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath enables.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        alu_src,
    output logic [1:0]  imm_sel,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] IMM_I    = 2'd0;
    localparam logic [1:0] IMM_S    = 2'd1;
    localparam logic [1:0] IMM_B    = 2'd2;
    localparam logic [1:0] IMM_NONE = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_SYSTEM  = 2'd2;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd3;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [6:0] opcode_q;
    logic [7:0] wait_q;
    logic       halted_q;
    logic [1:0] fault_q, fault_d;

    logic       req, we, irw, pinc, pld, asrc, rw;
    logic [1:0] isel, wsel;

    // Only the opcode field steers the sequencer; the rest belongs to the datapath.
    logic unused_instr_hi;
    assign unused_instr_hi = ^instr[31:7];

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        req     = 1'b0;
        we      = 1'b0;
        irw     = 1'b0;
        pinc    = 1'b0;
        pld     = 1'b0;
        asrc    = 1'b0;
        isel    = IMM_NONE;
        rw      = 1'b0;
        wsel    = WB_ALU;
        case (state_q)
            S_FETCH: begin
                req = 1'b1;
                if (mem_ready) begin
                    irw     = 1'b1;
                    pinc    = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == TIMEOUT) begin
                    state_d = S_HALT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            S_DECODE: begin
                // The latched opcode is not valid until next cycle, so decode straight from instr.
                case (instr[6:0])
                    OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: state_d = S_EXEC;
                    OP_SYSTEM: begin
                        state_d = S_HALT;
                        fault_d = FAULT_SYSTEM;
                    end
                    default: begin
                        state_d = S_HALT;
                        fault_d = FAULT_ILLEGAL;
                    end
                endcase
            end
            S_EXEC: begin
                case (opcode_q)
                    OP_R:            state_d = S_WB;
                    OP_I: begin
                        asrc    = 1'b1;
                        isel    = IMM_I;
                        state_d = S_WB;
                    end
                    OP_LOAD: begin
                        asrc    = 1'b1;
                        isel    = IMM_I;
                        state_d = S_MEM;
                    end
                    OP_STORE: begin
                        asrc    = 1'b1;
                        isel    = IMM_S;
                        state_d = S_MEM;
                    end
                    OP_BRANCH: begin
                        isel    = IMM_B;
                        pld     = branch_taken;
                        state_d = S_FETCH;
                    end
                    OP_JALR: begin
                        asrc    = 1'b1;
                        isel    = IMM_I;
                        pld     = 1'b1;
                        state_d = S_WB;
                    end
                    default: begin
                        state_d = S_HALT;
                        fault_d = FAULT_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                req = 1'b1;
                we  = (opcode_q == OP_STORE);
                if (mem_ready) begin
                    state_d = (opcode_q == OP_STORE) ? S_FETCH : S_WB;
                end else if (wait_q == TIMEOUT) begin
                    state_d = S_HALT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            S_WB: begin
                rw      = 1'b1;
                wsel    = (opcode_q == OP_LOAD) ? WB_MEM :
                          (opcode_q == OP_JALR) ? WB_PC4 : WB_ALU;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            wait_q   <= '0;
            halted_q <= 1'b0;
            fault_q  <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            if (state_q == S_DECODE) opcode_q <= instr[6:0];
            // Any state change restarts the wait count, covering entry to FETCH and MEM.
            if (state_d != state_q)        wait_q <= '0;
            else if (req && !mem_ready)    wait_q <= wait_q + 8'd1;
            if (state_d == S_HALT)         halted_q <= 1'b1;
        end
    end

    // Reset masks every output so no stray enable fires in the reset cycle.
    assign mem_req   = req  & ~reset;
    assign mem_we    = we   & ~reset;
    assign ir_write  = irw  & ~reset;
    assign pc_inc    = pinc & ~reset;
    assign pc_load   = pld  & ~reset;
    assign alu_src   = asrc & ~reset;
    assign reg_write = rw   & ~reset;
    assign imm_sel   = reset ? 2'd0 : isel;
    assign wb_sel    = reset ? 2'd0 : wsel;
    assign halted    = halted_q & ~reset;
    assign fault     = reset ? 2'd0 : fault_q;
    assign state     = reset ? 3'd0 : state_q;

endmodule
